// File: rtl/irq_pending_if.sv
// irq_pending_if: request/mask inputs, valid/ready index handshake and status outputs of irq_pending_ctrl
//   req       request lines, bit k = request k raised this cycle
//   mask      1 = request k ineligible for selection
//   irq_valid irq_id holds a selected index
//   irq_ready consumer accepts irq_id this cycle
//   irq_id    index of the selected request
//   pending   sticky pending register
//   overrun   one-cycle pulse on a request hitting an already pending bit
//   serv_cnt  accepted-handshake counter, wraps
interface irq_pending_if #(
    parameter int N     = 16,
    parameter int IDW   = 4,
    parameter int CNT_W = 8
);
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic             irq_valid;
    logic             irq_ready;
    logic [IDW-1:0]   irq_id;
    logic [N-1:0]     pending;
    logic             overrun;
    logic [CNT_W-1:0] serv_cnt;
    modport master (
        input  req, mask, irq_ready,
        output irq_valid, irq_id, pending, overrun, serv_cnt
    );
    modport slave (
        output req, mask, irq_ready,
        input  irq_valid, irq_id, pending, overrun, serv_cnt
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: sticky 16-line pending register with mask, lowest-index priority select and valid/ready index handoff
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    irq_pending_if.master: req/mask/irq_ready in; irq_valid/irq_id/pending/overrun/serv_cnt out
module irq_pending_ctrl #(
    parameter int N     = 16,
    parameter int IDW   = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    irq_pending_if.master bus
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t           state, state_n;
    logic [N-1:0]     pending, clr, eligible;
    logic [IDW-1:0]   irq_id, sel;
    logic [CNT_W-1:0] serv_cnt;
    logic             overrun, irq_valid, accept;
    always_comb begin
        accept   = irq_valid & bus.irq_ready;
        clr      = accept ? ({{(N-1){1'b0}}, 1'b1} << irq_id) : '0;
        eligible = pending & ~bus.mask;
    end
    // descending scan so the lowest set bit is the last (winning) assignment
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--)
            if (eligible[i]) sel = IDW'(i);
    end
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = |eligible    ? PRESENT : IDLE;
        else               state_n = bus.irq_ready ? IDLE    : PRESENT;
    end
    always_comb irq_valid = (state == PRESENT);
    // set wins over clear: a request on the bit being accepted keeps it pending
    always_ff @(posedge clk)
        if (!rst_n) begin
            pending  <= '0;
            overrun  <= 1'b0;
            irq_id   <= '0;
            serv_cnt <= '0;
        end else begin
            pending  <= (pending & ~clr) | bus.req;
            overrun  <= |(bus.req & pending & ~clr);
            irq_id   <= (state == IDLE && |eligible) ? sel : irq_id;
            serv_cnt <= serv_cnt + CNT_W'(accept);
        end
    assign bus.irq_valid = irq_valid;
    assign bus.irq_id    = irq_id;
    assign bus.pending   = pending;
    assign bus.overrun   = overrun;
    assign bus.serv_cnt  = serv_cnt;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: directed and random stimulus against a per-request behavioural model
module tb_irq_pending_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    irq_pending_if bus ();
    irq_pending_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    bit m_pend [16];
    bit m_busy;
    int m_id;
    int m_cnt;
    bit m_ovr;
    function automatic logic [15:0] m_pack();
        logic [15:0] v = '0;
        for (int k = 0; k < 16; k++) v[k] = m_pend[k];
        return v;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic [15:0] r, input logic [15:0] m, input logic rdy, input logic rs);
        bit acc;
        int found;
        bit np [16];
        bus.req = r;
        bus.mask = m;
        bus.irq_ready = rdy;
        rst_n = rs;
        if (!rs) begin
            for (int k = 0; k < 16; k++) m_pend[k] = 0;
            m_busy = 0; m_id = 0; m_cnt = 0; m_ovr = 0;
        end else begin
            acc = m_busy && rdy;
            m_ovr = 0;
            for (int k = 0; k < 16; k++) begin
                bit cleared = acc && (k == m_id);
                if (r[k] && m_pend[k] && !cleared) m_ovr = 1;
                np[k] = (m_pend[k] && !cleared) || r[k];
            end
            if (!m_busy) begin
                found = -1;
                for (int k = 15; k >= 0; k--) if (m_pend[k] && !m[k]) found = k;
                if (found >= 0) begin m_id = found; m_busy = 1; end
            end else if (rdy) begin
                m_busy = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
            for (int k = 0; k < 16; k++) m_pend[k] = np[k];
        end
        @(posedge clk);
        #1;
        chk("pending",  32'(bus.pending),   32'(m_pack()));
        chk("valid",    32'(bus.irq_valid), 32'(m_busy));
        chk("id",       32'(bus.irq_id),    32'(m_id));
        chk("overrun",  32'(bus.overrun),   32'(m_ovr));
        chk("serv_cnt", 32'(bus.serv_cnt),  32'(m_cnt));
    endtask
    initial begin
        bus.req = '0; bus.mask = '0; bus.irq_ready = 1'b0; rst_n = 1'b0;
        // reset with all requests high
        step(16'hFFFF, 0, 1, 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_valid", 32'(bus.irq_valid), 0);
        step(0, 0, 0, 1);
        // single request, index 5
        step(16'h0020, 0, 1, 1);
        chk("single_novalid", 32'(bus.irq_valid), 0);
        step(0, 0, 1, 1);
        chk("single_valid", 32'(bus.irq_valid), 1);
        chk("single_id", 32'(bus.irq_id), 5);
        step(0, 0, 1, 1);
        chk("single_cnt", 32'(bus.serv_cnt), 1);
        chk("single_pend", 32'(bus.pending), 0);
        // priority and hold
        step(16'h8100, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("hold_id8", 32'(bus.irq_id), 8);
        step(16'h0004, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("hold_still8", 32'(bus.irq_id), 8);
        step(0, 0, 1, 1);
        chk("gap1", 32'(bus.irq_valid), 0);
        step(0, 0, 1, 1);
        chk("then_id2", 32'(bus.irq_id), 2);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("then_id15", 32'(bus.irq_id), 15);
        step(0, 0, 1, 1);
        // mask
        step(16'h0003, 16'h0001, 0, 1);
        repeat (4) step(0, 16'h0001, 1, 1);
        chk("mask_bit0_kept", 32'(bus.pending), 1);
        repeat (3) step(0, 0, 1, 1);
        chk("unmask_served", 32'(bus.pending), 0);
        // overrun and set-wins
        step(16'h0010, 0, 0, 1);
        step(16'h0010, 0, 0, 1);
        chk("ovr_pulse", 32'(bus.overrun), 1);
        step(0, 0, 0, 1);
        chk("ovr_drop", 32'(bus.overrun), 0);
        step(16'h0010, 0, 1, 1);
        chk("setwins_noovr", 32'(bus.overrun), 0);
        chk("setwins_pend", 32'(bus.pending), 32'h10);
        step(0, 0, 1, 1);
        chk("represent", 32'(bus.irq_id), 4);
        step(0, 0, 1, 1);
        // reset mid-PRESENT
        step(16'h0008, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("mid_id3", 32'(bus.irq_id), 3);
        step(0, 0, 0, 0);
        chk("mid_valid", 32'(bus.irq_valid), 0);
        step(0, 0, 0, 1);
        // counter wrap
        for (int n = 0; n < 256; n++) begin
            step(16'h0001, 0, 0, 1);
            step(0, 0, 1, 1);
            step(0, 0, 1, 1);
            if (n == 254) chk("cnt255", 32'(bus.serv_cnt), 255);
        end
        chk("cnt_wrap", 32'(bus.serv_cnt), 0);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r, m;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            m = 16'($urandom) & 16'($urandom);
            step(r, m, 1'($urandom), ($urandom_range(0, 63) != 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
